// File: rtl/key_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : key_press_classifier
// Purpose  : Turns debounced key events into short / long / double-click pulses.
// Revision : 1.0 - initial release
// ============================================================================
module key_press_classifier #(
    parameter int LONG_CNT = 50_000_000,
    parameter int DBL_GAP  = 12_500_000,
    parameter int CNT_W    = 26
) (
    input  logic Clk,
    input  logic Rst,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HOLD = 3'd2,
        WAIT_GAP  = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_GAP - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              dbl_q, dbl_d;
    logic              busy_q, busy_d;

    logic press_ev;
    logic rel_ev;

    assign press_ev = key_flag & ~key_state;
    assign rel_ev   = key_flag &  key_state;

    // Release beats the long-press terminal count, press beats gap expiry.
    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_ev) state_d = PRESS1;
            end
            PRESS1: begin
                if (rel_ev) begin
                    state_d = WAIT_GAP;
                end else if (cnt_q == LONG_TC) begin
                    state_d = LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (rel_ev) state_d = IDLE;
            end
            WAIT_GAP: begin
                if (press_ev) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_TC) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (rel_ev) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == PRESS1) || (state_q == WAIT_GAP))) begin
            cnt_d = cnt_q + 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            busy_q  <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_press_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_press_classifier
// Purpose  : Directed and randomized gesture checks for key_press_classifier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_press_classifier;

    localparam int LC = 100;
    localparam int DG = 50;
    localparam int N  = 1024;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b1;
    logic short_press, long_press, double_click, busy;

    int         ev [0:N-1];   // 0 none, 1 press, 2 release, 3 reset
    logic [3:0] ob [0:N-1];   // {busy, double_click, long_press, short_press}
    int         n_cmp = 0;
    int         n_fail = 0;

    always #5 Clk = ~Clk;

    key_press_classifier #(.LONG_CNT(LC), .DBL_GAP(DG), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .key_flag(key_flag), .key_state(key_state),
        .short_press(short_press), .long_press(long_press),
        .double_click(double_click), .busy(busy)
    );

    task automatic clear_ev();
        for (int i = 0; i < N; i++) ev[i] = 0;
        for (int i = 0; i < 3; i++) ev[i] = 3;
    endtask

    // ob[c] holds the outputs visible during cycle c; ev[c] is sampled at the end of cycle c.
    task automatic run(input int len);
        for (int c = 0; c <= len; c++) begin
            @(negedge Clk);
            ob[c]     = {busy, double_click, long_press, short_press};
            Rst       = (c < len) && (ev[c] == 3);
            key_flag  = (c < len) && ((ev[c] == 1) || (ev[c] == 2));
            key_state = (c < len) ? (ev[c] != 1) : 1'b1;
        end
    endtask

    function automatic int cnt_bit(input int b, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (ob[c][b] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        int bad = -1;
        clear_ev();
        run(510);
        for (int c = 510; c >= 1; c--) if (ob[c] !== 4'b0000) bad = c;
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL reset_idle: cycle %0d outputs=%b required=0000", bad, ob[bad]);
        end
    endtask

    task automatic test_short();
        int bad = -1;
        clear_ev(); ev[10] = 1; ev[40] = 2;
        run(200);
        n_cmp++; if (ob[91][0] !== 1'b1) begin n_fail++; $display("FAIL short_at_91: got %b required 1", ob[91][0]); end
        n_cmp++; if (cnt_bit(0, 4, 200) != 1) begin n_fail++; $display("FAIL short_count: got %0d required 1", cnt_bit(0, 4, 200)); end
        n_cmp++; if (cnt_bit(1, 4, 200) + cnt_bit(2, 4, 200) != 0) begin n_fail++; $display("FAIL short_other_pulses: got %0d required 0", cnt_bit(1, 4, 200) + cnt_bit(2, 4, 200)); end
        for (int c = 90; c >= 11; c--) if (ob[c][3] !== 1'b1) bad = c;
        n_cmp++; if (bad >= 0 || ob[10][3] !== 1'b0) begin n_fail++; $display("FAIL short_busy_span: first bad cycle %0d busy@10=%b required high 11..90", bad, ob[10][3]); end
        n_cmp++; if (ob[92][3] !== 1'b0) begin n_fail++; $display("FAIL short_busy_92: got %b required 0", ob[92][3]); end
    endtask

    task automatic test_long();
        clear_ev(); ev[10] = 1; ev[300] = 2;
        run(400);
        n_cmp++; if (ob[111][1] !== 1'b1) begin n_fail++; $display("FAIL long_at_111: got %b required 1", ob[111][1]); end
        n_cmp++; if (cnt_bit(1, 4, 400) != 1) begin n_fail++; $display("FAIL long_count: got %0d required 1", cnt_bit(1, 4, 400)); end
        n_cmp++; if (cnt_bit(0, 4, 400) + cnt_bit(2, 4, 400) != 0) begin n_fail++; $display("FAIL long_other_pulses: got %0d required 0", cnt_bit(0, 4, 400) + cnt_bit(2, 4, 400)); end
        n_cmp++; if (ob[300][3] !== 1'b1 || ob[302][3] !== 1'b0) begin n_fail++; $display("FAIL long_busy: busy@300=%b busy@302=%b required 1/0", ob[300][3], ob[302][3]); end
    endtask

    task automatic test_double();
        clear_ev(); ev[10] = 1; ev[30] = 2; ev[60] = 1; ev[75] = 2;
        run(300);
        n_cmp++; if (ob[76][2] !== 1'b1) begin n_fail++; $display("FAIL double_at_76: got %b required 1", ob[76][2]); end
        n_cmp++; if (cnt_bit(2, 4, 300) != 1) begin n_fail++; $display("FAIL double_count: got %0d required 1", cnt_bit(2, 4, 300)); end
        n_cmp++; if (cnt_bit(0, 4, 300) + cnt_bit(1, 4, 300) != 0) begin n_fail++; $display("FAIL double_other_pulses: got %0d required 0", cnt_bit(0, 4, 300) + cnt_bit(1, 4, 300)); end
        n_cmp++; if (ob[78][3] !== 1'b0) begin n_fail++; $display("FAIL double_busy_78: got %b required 0", ob[78][3]); end
    endtask

    task automatic test_collision();
        // release just before and exactly on the long-press terminal count
        for (int k = 0; k < 2; k++) begin
            clear_ev(); ev[10] = 1; ev[109 + k] = 2;
            run(300);
            n_cmp++; if (cnt_bit(1, 4, 300) != 0) begin n_fail++; $display("FAIL coll_a%0d_no_long: got %0d required 0", k, cnt_bit(1, 4, 300)); end
            n_cmp++; if (ob[160 + k][0] !== 1'b1 || cnt_bit(0, 4, 300) != 1) begin n_fail++; $display("FAIL coll_a%0d_short: at %0d got %b count %0d required 1/1", k, 160 + k, ob[160 + k][0], cnt_bit(0, 4, 300)); end
        end
        clear_ev(); ev[10] = 1; ev[30] = 2; ev[80] = 1; ev[90] = 2;
        run(300);
        n_cmp++; if (ob[91][2] !== 1'b1 || cnt_bit(2, 4, 300) != 1) begin n_fail++; $display("FAIL coll_b_double: got %b count %0d required 1/1", ob[91][2], cnt_bit(2, 4, 300)); end
        n_cmp++; if (cnt_bit(0, 4, 300) != 0) begin n_fail++; $display("FAIL coll_b_no_short: got %0d required 0", cnt_bit(0, 4, 300)); end
    endtask

    task automatic test_back_to_back();
        // press lands on the first cycle back in IDLE after the gap expires
        clear_ev(); ev[10] = 1; ev[30] = 2; ev[81] = 1; ev[90] = 2;
        run(300);
        n_cmp++; if (ob[81][0] !== 1'b1 || ob[141][0] !== 1'b1 || cnt_bit(0, 4, 300) != 2) begin
            n_fail++; $display("FAIL b2b_shorts: @81=%b @141=%b count %0d required 1/1/2", ob[81][0], ob[141][0], cnt_bit(0, 4, 300));
        end
        n_cmp++; if (cnt_bit(2, 4, 300) != 0) begin n_fail++; $display("FAIL b2b_no_double: got %0d required 0", cnt_bit(2, 4, 300)); end
    endtask

    task automatic test_reset_mid();
        int bad = -1;
        clear_ev(); ev[10] = 1; ev[60] = 3;
        run(400);
        n_cmp++; if (cnt_bit(0, 4, 400) + cnt_bit(1, 4, 400) + cnt_bit(2, 4, 400) != 0) begin
            n_fail++; $display("FAIL rstmid_pulses: got %0d required 0", cnt_bit(0, 4, 400) + cnt_bit(1, 4, 400) + cnt_bit(2, 4, 400));
        end
        for (int c = 400; c >= 61; c--) if (ob[c][3] !== 1'b0) bad = c;
        n_cmp++; if (bad >= 0 || ob[59][3] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: first busy cycle %0d busy@59=%b required none/1", bad, ob[59][3]); end
    endtask

    task automatic test_spurious();
        int bad = -1;
        clear_ev(); ev[10] = 2; ev[20] = 1; ev[25] = 1; ev[30] = 2;
        run(200);
        for (int c = 20; c >= 4; c--) if (ob[c] !== 4'b0000) bad = c;
        n_cmp++; if (bad >= 0) begin n_fail++; $display("FAIL spur_idle_release: cycle %0d outputs=%b required 0000", bad, ob[bad]); end
        n_cmp++; if (ob[81][0] !== 1'b1 || cnt_bit(0, 4, 200) != 1) begin n_fail++; $display("FAIL spur_short: @81=%b count %0d required 1/1", ob[81][0], cnt_bit(0, 4, 200)); end
        n_cmp++; if (cnt_bit(1, 4, 200) + cnt_bit(2, 4, 200) != 0) begin n_fail++; $display("FAIL spur_other: got %0d required 0", cnt_bit(1, 4, 200) + cnt_bit(2, 4, 200)); end
    endtask

    // Reference: gesture outcome derived from hold/gap lengths against the thresholds.
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int t0, h, g, h2, r, t_sp, t_lp, t_dc, e, bad_p, bad_b;
            logic [2:0] exp_p;
            t0 = $urandom_range(5, 20);
            case ($urandom_range(0, 5))
                0: h = LC;
                1: h = LC + 1;
                2: h = $urandom_range(LC + 2, 150);
                default: h = $urandom_range(1, LC - 1);
            endcase
            case ($urandom_range(0, 4))
                0: g = DG;
                1: g = DG + 1;
                2: g = $urandom_range(DG + 2, 80);
                default: g = $urandom_range(1, DG - 1);
            endcase
            h2 = $urandom_range(1, 40);
            r = t0 + h;
            t_sp = -1; t_lp = -1; t_dc = -1;
            clear_ev(); ev[t0] = 1; ev[r] = 2;
            if (h > LC) begin
                t_lp = t0 + LC + 1;
                e = r + 1;
            end else if (g <= DG) begin
                ev[r + g] = 1; ev[r + g + h2] = 2;
                t_dc = r + g + h2 + 1;
                e = t_dc;
            end else begin
                t_sp = r + DG + 1;
                e = t_sp;
            end
            run(260);
            bad_p = -1; bad_b = -1;
            for (int c = 260; c >= 4; c--) begin
                exp_p = {c == t_dc, c == t_lp, c == t_sp};
                if (ob[c][2:0] !== exp_p) bad_p = c;
                if (c != e && ob[c][3] !== ((c > t0) && (c < e))) bad_b = c;
            end
            n_cmp++;
            if (bad_p >= 0) begin
                n_fail++;
                $display("FAIL rand%0d_pulses: t0=%0d h=%0d g=%0d h2=%0d cycle %0d got %b required %b",
                         it, t0, h, g, h2, bad_p, ob[bad_p][2:0], {bad_p == t_dc, bad_p == t_lp, bad_p == t_sp});
            end
            n_cmp++;
            if (bad_b >= 0) begin
                n_fail++;
                $display("FAIL rand%0d_busy: t0=%0d h=%0d g=%0d cycle %0d got %b required %b",
                         it, t0, h, g, bad_b, ob[bad_b][3], (bad_b > t0) && (bad_b < e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
